// File: rtl/cpu_run_controller.sv
// Run controller for the 16-bit core: reset hold, run until halt or budget, drain,
// then stream a data-memory window out; PC-watch trace words share the output slot.
module cpu_run_controller #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                RESET_CYCLES = 4,
    parameter int                DRAIN_CYCLES = 10,
    parameter logic [DATA_W-1:0] HALT_OP0     = 16'hE000,
    parameter logic [DATA_W-1:0] HALT_OP1     = 16'hE7FF,
    parameter int                CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_len,
    input  logic              skip_zero,
    input  logic              watch_en,
    input  logic [ADDR_W-1:0] watch_pc,
    input  logic [DATA_W-1:0] watch_data,
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_is_trace,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              trace_overflow
);
    typedef enum logic [2:0] {IDLE, RST_HOLD, RUN, DRAIN, DUMP, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  max_cycles;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
        logic              skip_zero;
    } cfg_t;

    localparam int HOLD_W = 16;
    localparam logic [HOLD_W-1:0] RST_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DRN_LAST = HOLD_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t            state, state_n;
    cfg_t              cfg;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr_q;

    logic is_halt, budget_hit, out_xfer, slot_free, trace_hit, rd_keep, rd_done, start_ok;

    always_comb begin
        is_halt    = (instr == HALT_OP0) || (instr == HALT_OP1);
        budget_hit = (cfg.max_cycles != '0) && ((cycle_count + CNT_W'(1)) == cfg.max_cycles);
        out_xfer   = out_valid && out_ready;
        slot_free  = !out_valid || out_ready;
        trace_hit  = (state == RUN || state == DRAIN) && watch_en && (pc == watch_pc);
        // a returning read is kept unless zero-skipping drops it
        rd_keep    = rd_pend && !(cfg.skip_zero && mem_rd_data == '0);
        rd_done    = (rd_cnt == cfg.len);
        start_ok   = (state == IDLE || state == DONE) && start;
        mem_rd_en  = (state == DUMP) && !rd_pend && !rd_done && slot_free;
        mem_rd_addr = cfg.base + rd_cnt;
        cpu_reset  = !(state == RUN || state == DRAIN);
        busy       = !(state == IDLE || state == DONE);
        done       = (state == DONE);

        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = RST_HOLD;
            RST_HOLD:   if (hold_cnt == RST_LAST) state_n = RUN;
            RUN:        if (is_halt || budget_hit) state_n = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
            DRAIN:      if (hold_cnt == DRN_LAST) state_n = DUMP;
            // finish once everything is read and the last word is gone or dropped
            DUMP:       if (rd_done && (rd_pend ? !rd_keep : slot_free)) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cfg            <= '0;
            hold_cnt       <= '0;
            rd_cnt         <= '0;
            rd_pend        <= 1'b0;
            rd_addr_q      <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_addr       <= '0;
            out_is_trace   <= 1'b0;
            cycle_count    <= '0;
            timed_out      <= 1'b0;
            trace_overflow <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= (state_n == state) ? hold_cnt + HOLD_W'(1) : '0;
            rd_pend  <= mem_rd_en;
            if (mem_rd_en) begin
                rd_addr_q <= mem_rd_addr;
                rd_cnt    <= rd_cnt + ADDR_W'(1);
            end
            if (start_ok) begin
                cfg.max_cycles <= max_cycles;
                cfg.base       <= dump_base;
                cfg.len        <= dump_len;
                cfg.skip_zero  <= skip_zero;
                rd_cnt         <= '0;
                cycle_count    <= '0;
                timed_out      <= 1'b0;
                trace_overflow <= 1'b0;
            end
            if (state == RUN) begin
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                if (!is_halt && budget_hit) timed_out <= 1'b1;
            end
            if (out_xfer) out_valid <= 1'b0;
            if (trace_hit) begin
                if (slot_free) begin
                    out_valid    <= 1'b1;
                    out_data     <= watch_data;
                    out_addr     <= pc;
                    out_is_trace <= 1'b1;
                end else begin
                    trace_overflow <= 1'b1;
                end
            end
            if (state == DUMP && rd_keep) begin
                out_valid    <= 1'b1;
                out_data     <= mem_rd_data;
                out_addr     <= rd_addr_q;
                out_is_trace <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: core/memory models plus a word-list reference
// derived from the run rules (halt/budget, drain length, dump window, trace hits).
module tb_cpu_run_controller;
    localparam int RSTC = 4;
    localparam int DRNC = 10;

    logic        clk = 1'b0;
    logic        reset, start, skip_zero, watch_en, out_ready;
    logic [31:0] max_cycles, cycle_count;
    logic [15:0] dump_base, dump_len, watch_pc, watch_data, instr, pc;
    logic [15:0] mem_rd_addr, mem_rd_data, out_data, out_addr;
    logic        cpu_reset, mem_rd_en, out_valid, out_is_trace, busy, done, timed_out, trace_overflow;

    always #5 clk = ~clk;

    cpu_run_controller dut (
        .clk(clk), .reset(reset), .start(start), .max_cycles(max_cycles),
        .dump_base(dump_base), .dump_len(dump_len), .skip_zero(skip_zero),
        .watch_en(watch_en), .watch_pc(watch_pc), .watch_data(watch_data),
        .instr(instr), .pc(pc), .cpu_reset(cpu_reset), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_is_trace(out_is_trace), .cycle_count(cycle_count), .busy(busy),
        .done(done), .timed_out(timed_out), .trace_overflow(trace_overflow)
    );

    // data memory with one-cycle read latency
    logic [15:0] mem [0:65535];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // core model: core_cyc = RUN/DRAIN cycles since the core left reset
    int          core_cyc = 0;
    int          halt_at;
    logic [15:0] halt_op;
    bit          hit_tab [0:255];
    always @(posedge clk) core_cyc <= cpu_reset ? 0 : core_cyc + 1;
    assign instr = (halt_at != 0 && core_cyc == halt_at - 1) ? halt_op : 16'h0001;
    assign pc    = (core_cyc < 256 && hit_tab[core_cyc]) ? watch_pc : 16'(32'h1000 + core_cyc);

    typedef struct packed { logic tr; logic [15:0] addr; logic [15:0] data; } word_t;
    word_t got[$];
    word_t exp_q[$];
    int    exp_cc;
    bit    exp_to, exp_ovf;
    int    tests = 0, fails = 0;
    int    rst_hold, low_cyc, dump_cyc, last_hs, done_at, stab_err, rdy_mode;
    bit    to_flag, start_mid;

    task automatic clear_hits();
        for (int i = 0; i < 256; i++) hit_tab[i] = 1'b0;
    endtask

    // reference: run length from halt/budget rules, then trace words, then the dump window
    task automatic model(input logic [31:0] maxc, input logic [15:0] base, input logic [15:0] len,
                         input bit skip, input bit stall_trace);
        int nh = 0;
        logic [15:0] a;
        exp_q.delete();
        if (halt_at != 0 && (maxc == 0 || halt_at <= int'(maxc))) begin exp_cc = halt_at; exp_to = 0; end
        else begin exp_cc = int'(maxc); exp_to = 1; end
        for (int i = 0; i < 256; i++)
            if (watch_en && hit_tab[i] && i < exp_cc + DRNC) begin
                nh++;
                if (!stall_trace || nh == 1) exp_q.push_back({1'b1, watch_pc, watch_data});
            end
        exp_ovf = stall_trace && nh > 1;
        for (int k = 0; k < int'(len); k++) begin
            a = base + 16'(k);
            if (!(skip && mem[a] == 16'h0)) exp_q.push_back({1'b0, a, mem[a]});
        end
    endtask

    function automatic int first_diff();
        int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // launch one run and observe it on negedges until done (bounded)
    task automatic run(input logic [31:0] maxc, input logic [15:0] base, input logic [15:0] len, input bit skip);
        word_t prev_w = '0;
        bit    prev_stall = 0, mid_done = 0;
        got.delete();
        rst_hold = 0; low_cyc = 0; dump_cyc = 0; last_hs = -1; done_at = -1; stab_err = 0; to_flag = 0;
        @(negedge clk);
        max_cycles = maxc; dump_base = base; dump_len = len; skip_zero = skip; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done) begin done_at = c; break; end
            if (cpu_reset && low_cyc == 0) rst_hold++;
            else if (!cpu_reset) low_cyc++;
            else dump_cyc++;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = cpu_reset && low_cyc > 0;
                default: out_ready = !(cpu_reset && low_cyc > 0 && dump_cyc >= 3 && dump_cyc < 8);
            endcase
            if (prev_stall && (out_valid !== 1'b1 || {out_is_trace, out_addr, out_data} !== prev_w)) stab_err++;
            prev_stall = out_valid && !out_ready;
            prev_w = {out_is_trace, out_addr, out_data};
            if (out_valid && out_ready) begin got.push_back({out_is_trace, out_addr, out_data}); last_hs = c; end
            if (start_mid && !mid_done && !cpu_reset && low_cyc == 5) begin
                start = 1'b1; max_cycles = 32'd3; dump_len = 16'd0; mid_done = 1;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        if (done_at < 0) to_flag = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({cpu_reset, mem_rd_en, out_valid, out_is_trace, busy, done, timed_out, trace_overflow} !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_flags: got %b exp 10000000",
                     {cpu_reset, mem_rd_en, out_valid, out_is_trace, busy, done, timed_out, trace_overflow});
        end
        tests++;
        if (out_data !== 16'h0 || out_addr !== 16'h0 || cycle_count !== 32'h0) begin
            fails++;
            $display("FAIL reset_values: data %h addr %h cnt %0d exp 0 0 0", out_data, out_addr, cycle_count);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
            fails++;
            $display("FAIL idle_after_reset: busy %b cpu_reset %b exp 0 1", busy, cpu_reset);
        end
    endtask

    task automatic test_halt();
        int d;
        mem[0] = 16'h0; mem[1] = 16'h5; mem[2] = 16'h0; mem[3] = 16'h9;
        clear_hits(); halt_at = 20; halt_op = 16'hE000; rdy_mode = 0; watch_en = 0;
        model(0, 16'h0, 16'd4, 0, 0);
        run(0, 16'h0, 16'd4, 0);
        tests++; if (to_flag) begin fails++; $display("FAIL halt_budget: no done within bound, got 0 exp 1"); end
        tests++; if (rst_hold !== RSTC) begin fails++; $display("FAIL halt_rst_hold: got %0d exp %0d", rst_hold, RSTC); end
        tests++; if (cycle_count !== 32'(exp_cc) || timed_out !== exp_to) begin
            fails++; $display("FAIL halt_count: cnt %0d to %b exp %0d %b", cycle_count, timed_out, exp_cc, exp_to); end
        tests++; if (low_cyc !== exp_cc + DRNC) begin fails++; $display("FAIL halt_drain: low %0d exp %0d", low_cyc, exp_cc + DRNC); end
        tests++; d = first_diff();
        if (d != -1) begin fails++; $display("FAIL halt_words: idx %0d got n=%0d exp n=%0d", d, got.size(), exp_q.size()); end
        tests++; if (dump_cyc !== 9 || done_at - last_hs !== 1) begin
            fails++; $display("FAIL halt_dump_timing: dump %0d gap %0d exp 9 1", dump_cyc, done_at - last_hs); end
    endtask

    task automatic test_start_while_busy();
        int d;
        clear_hits(); halt_at = 20; halt_op = 16'hE000; rdy_mode = 0; watch_en = 0; start_mid = 1;
        model(0, 16'h0, 16'd4, 0, 0);
        run(0, 16'h0, 16'd4, 0);
        start_mid = 0;
        tests++; if (to_flag || cycle_count !== 32'(exp_cc) || rst_hold !== RSTC) begin
            fails++; $display("FAIL busy_start: to %b cnt %0d hold %0d exp 0 %0d %0d", to_flag, cycle_count, rst_hold, exp_cc, RSTC); end
        tests++; d = first_diff();
        if (d != -1) begin fails++; $display("FAIL busy_start_words: idx %0d got n=%0d exp n=%0d", d, got.size(), exp_q.size()); end
    endtask

    task automatic test_timeout();
        int d;
        clear_hits(); halt_at = 0; halt_op = 16'hE7FF; rdy_mode = 0; watch_en = 0;
        model(32'd50, 16'h0, 16'd4, 0, 0);
        run(32'd50, 16'h0, 16'd4, 0);
        tests++; if (to_flag || cycle_count !== 32'd50 || timed_out !== 1'b1) begin
            fails++; $display("FAIL timeout: to %b cnt %0d timed_out %b exp 0 50 1", to_flag, cycle_count, timed_out); end
        tests++; d = first_diff();
        if (d != -1) begin fails++; $display("FAIL timeout_words: idx %0d got n=%0d exp n=%0d", d, got.size(), exp_q.size()); end
        halt_at = 50;
        model(32'd50, 16'h0, 16'd4, 0, 0);
        run(32'd50, 16'h0, 16'd4, 0);
        tests++; if (to_flag || cycle_count !== 32'd50 || timed_out !== 1'b0) begin
            fails++; $display("FAIL halt_on_budget: to %b cnt %0d timed_out %b exp 0 50 0", to_flag, cycle_count, timed_out); end
    endtask

    task automatic test_skip_zero();
        int d;
        clear_hits(); halt_at = 8; halt_op = 16'hE000; rdy_mode = 0; watch_en = 0;
        model(0, 16'h0, 16'd4, 1, 0);
        run(0, 16'h0, 16'd4, 1);
        tests++; d = first_diff();
        if (to_flag || d != -1) begin fails++; $display("FAIL skip_words: to %b idx %0d got n=%0d exp n=%0d", to_flag, d, got.size(), exp_q.size()); end
        tests++; if (got.size() !== 2) begin fails++; $display("FAIL skip_count: got %0d exp 2", got.size()); end
    endtask

    task automatic test_wrap_backpressure();
        int d;
        mem[16'hFFFE] = 16'h1111; mem[16'hFFFF] = 16'h2222; mem[16'h0000] = 16'h3333;
        clear_hits(); halt_at = 6; halt_op = 16'hE7FF; rdy_mode = 3; watch_en = 0;
        model(0, 16'hFFFE, 16'd3, 0, 0);
        run(0, 16'hFFFE, 16'd3, 0);
        tests++; d = first_diff();
        if (to_flag || d != -1) begin fails++; $display("FAIL wrap_words: to %b idx %0d got n=%0d exp n=%0d", to_flag, d, got.size(), exp_q.size()); end
        tests++; if (stab_err !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes exp 0", stab_err); end
    endtask

    task automatic test_trace();
        int d;
        mem[0] = 16'h0; mem[1] = 16'h5;
        clear_hits(); hit_tab[10] = 1; hit_tab[15] = 1; hit_tab[25] = 1;
        halt_at = 20; halt_op = 16'hE000; watch_en = 1; watch_pc = 16'h0078; watch_data = 16'hBEEF;
        rdy_mode = 0;
        model(0, 16'h0, 16'd2, 0, 0);
        run(0, 16'h0, 16'd2, 0);
        tests++; d = first_diff();
        if (to_flag || d != -1) begin fails++; $display("FAIL trace_words: to %b idx %0d got n=%0d exp n=%0d", to_flag, d, got.size(), exp_q.size()); end
        tests++; if (trace_overflow !== 1'b0) begin fails++; $display("FAIL trace_no_ovf: got %b exp 0", trace_overflow); end
        rdy_mode = 2;
        model(0, 16'h0, 16'd2, 0, 1);
        run(0, 16'h0, 16'd2, 0);
        tests++; d = first_diff();
        if (to_flag || d != -1) begin fails++; $display("FAIL trace_stall_words: to %b idx %0d got n=%0d exp n=%0d", to_flag, d, got.size(), exp_q.size()); end
        tests++; if (trace_overflow !== exp_ovf) begin fails++; $display("FAIL trace_ovf: got %b exp %b", trace_overflow, exp_ovf); end
        watch_en = 0;
    endtask

    task automatic test_len_zero();
        clear_hits(); halt_at = 3; halt_op = 16'hE000; rdy_mode = 0; watch_en = 0;
        run(0, 16'h0, 16'd0, 0);
        tests++; if (to_flag || dump_cyc !== 1 || got.size() !== 0 || low_cyc !== 3 + DRNC) begin
            fails++; $display("FAIL len_zero: to %b dump %0d words %0d low %0d exp 0 1 0 %0d", to_flag, dump_cyc, got.size(), low_cyc, 3 + DRNC); end
    endtask

    task automatic test_reset_in_dump();
        bit seen_low = 0;
        int k = 0;
        clear_hits(); halt_at = 5; halt_op = 16'hE000; watch_en = 0;
        @(negedge clk);
        max_cycles = 0; dump_base = 16'h0; dump_len = 16'd4; skip_zero = 0; out_ready = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && k < 3; c++) begin
            if (!cpu_reset) seen_low = 1;
            else if (seen_low && busy) k++;
            if (k < 3) @(negedge clk);
        end
        tests++; if (k !== 3 || out_valid !== 1'b1) begin fails++; $display("FAIL rst_dump_reach: k %0d valid %b exp 3 1", k, out_valid); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || cpu_reset !== 1'b1 || mem_rd_en !== 1'b0) begin
            fails++; $display("FAIL rst_dump_abort: busy %b done %b valid %b cpu_reset %b rd %b exp 0 0 0 1 0",
                              busy, done, out_valid, cpu_reset, mem_rd_en); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int d;
        logic [31:0] maxc;
        logic [15:0] base, len;
        bit skip;
        clear_hits(); watch_en = 0; rdy_mode = 1;
        for (int it = 0; it < 6; it++) begin
            halt_at = $urandom_range(0, 60);
            maxc    = 32'($urandom_range(0, 60));
            if (halt_at == 0 && maxc == 0) maxc = 32'd40;
            halt_op = ($urandom_range(0, 1) != 0) ? 16'hE000 : 16'hE7FF;
            base    = 16'($urandom);
            len     = 16'($urandom_range(0, 12));
            skip    = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'(len); k++)
                mem[base + 16'(k)] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            model(maxc, base, len, skip, 0);
            run(maxc, base, len, skip);
            tests++; if (to_flag || cycle_count !== 32'(exp_cc) || timed_out !== exp_to || rst_hold !== RSTC) begin
                fails++; $display("FAIL rand%0d_run: to %b cnt %0d tmo %b hold %0d exp 0 %0d %b %0d",
                                  it, to_flag, cycle_count, timed_out, rst_hold, exp_cc, exp_to, RSTC); end
            tests++; d = first_diff();
            if (d != -1 || stab_err !== 0) begin
                fails++; $display("FAIL rand%0d_words: idx %0d got n=%0d exp n=%0d unstable %0d exp 0",
                                  it, d, got.size(), exp_q.size(), stab_err); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; max_cycles = 0; dump_base = 0; dump_len = 0; skip_zero = 0;
        watch_en = 0; watch_pc = 16'h0078; watch_data = 16'h0; out_ready = 1'b1;
        halt_at = 0; halt_op = 16'hE000; rdy_mode = 0; start_mid = 0;
        clear_hits();
        test_reset();
        test_halt();
        test_start_while_busy();
        test_timeout();
        test_skip_zero();
        test_wrap_backpressure();
        test_trace();
        test_len_zero();
        test_reset_in_dump();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run controller for the 16-bit pipelined core.
- Holds the core in reset for a programmable number of cycles, then releases it and watches the fetched instruction for a halt opcode or a cycle-budget timeout.
- After a halt or timeout, drains the pipeline, then streams a programmable data-memory window out through a valid/ready port.
- While the core runs, it also emits trace words when the PC hits a watch address.
- Sits between the core/data memory and the host/debug interface.

Parameters:
DATA_W, 16, instruction/data word width
ADDR_W, 16, PC and data-memory address width
RESET_CYCLES, 4, cycles cpu_reset is held after start (min 1)
DRAIN_CYCLES, 10, cycles between halt detect and start of dump (min 0)
HALT_OP0, 16'hE000, first halt encoding
HALT_OP1, 16'hE7FF, second halt encoding
CNT_W, 32, width of cycle counter and budget

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins a run; ignored while busy
max_cycles  in  CNT_W  RUN-cycle budget, 0 = unlimited; sampled at start
dump_base  in  ADDR_W  first dump address; sampled at start
dump_len  in  ADDR_W  number of words to dump, 0 = none; sampled at start
skip_zero  in  1  drop dump words equal to 0; sampled at start
watch_en  in  1  trace enable
watch_pc  in  ADDR_W  trace PC match value
watch_data  in  DATA_W  value captured on trace match
instr  in  DATA_W  core decode-stage instruction
pc  in  ADDR_W  core PC
cpu_reset  out  1  reset to core
mem_rd_en  out  1  data-memory read strobe
mem_rd_addr  out  ADDR_W  data-memory read address
mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts
out_data  out  DATA_W  dump or trace word
out_addr  out  ADDR_W  memory address (dump) or PC (trace)
out_is_trace  out  1  1 = trace word, 0 = dump word
cycle_count  out  CNT_W  RUN cycles elapsed
busy  out  1  high in any state but IDLE/DONE
done  out  1  high in DONE
timed_out  out  1  sticky, run ended on budget
trace_overflow  out  1  sticky, trace word dropped

Behaviour:
- Reset values: state = IDLE, cpu_reset = 1, mem_rd_en = 0, out_valid = 0, out_data = 0, out_addr = 0, out_is_trace = 0, cycle_count = 0, busy = 0, done = 0, timed_out = 0, trace_overflow = 0.
- A reset mid-operation aborts immediately to IDLE; any pending output word is discarded.
- States:
  - IDLE: cpu_reset = 1. On start, go to RST_HOLD, clear cycle_count, timed_out and trace_overflow, and latch the sampled inputs.
  - RST_HOLD: cpu_reset = 1 for exactly RESET_CYCLES cycles, then RUN.
  - RUN: cpu_reset = 0; cycle_count increments each cycle.
    - If instr == HALT_OP0 or HALT_OP1, go to DRAIN.
    - Otherwise, if max_cycles != 0 and cycle_count + 1 == max_cycles, set timed_out and go to DRAIN.
    - A halt in the same cycle as budget expiry takes priority: timed_out stays 0.
    - cycle_count saturates at all-ones.
  - DRAIN: cpu_reset = 0 for exactly DRAIN_CYCLES cycles (0 means pass straight through), then DUMP. Trace matching stays active.
  - DUMP: cpu_reset = 1. If the latched len == 0, go to DONE at once.
  - DONE: done = 1 and cpu_reset = 1. A start pulse begins a new run, same as from IDLE.
- Trace (RUN and DRAIN only), when watch_en && pc == watch_pc:
  - If the output slot is free, or is being accepted this cycle, load out_data = watch_data, out_addr = pc, out_is_trace = 1, out_valid = 1.
  - Otherwise drop the word and set trace_overflow.
  - One trace word per matching cycle.
- Dump engine (DUMP), single outstanding read:
  - Issue mem_rd_en with mem_rd_addr = base + k when no read is pending, words remain, and the output slot is empty or handshaking this cycle.
  - The next cycle captures mem_rd_data into the slot with out_addr = the read address and out_is_trace = 0.
  - If skip_zero && data == 0, the word is dropped and the slot stays empty.
  - Peak throughput is 1 word per 2 cycles.
  - Addresses wrap modulo 2^ADDR_W.
  - Transition to DONE happens the cycle after the final word is accepted, or after the final read returns and is dropped.
- Output handshake:
  - A word transfers when out_valid && out_ready.
  - out_data, out_addr and out_is_trace are stable while out_valid && !out_ready.
  - Any trace word still pending on DRAIN→DUMP is delivered before the first dump word.
- start while busy is ignored.

Test Plan:
- start; RESET_CYCLES = 4; instr = 16'hE000 on RUN cycle 20 → cpu_reset high 4 cycles, cycle_count = 20, 10 drain cycles, then dump; timed_out = 0.
- Halt never seen, max_cycles = 50 → timed_out = 1, cycle_count = 50, dump still performed; halt on cycle 50 → timed_out = 0.
- Memory preloaded mem[0..3] = {0, 5, 0, 9}; base = 0, len = 4; skip_zero = 1 → exactly 2 words (addr1 = 5, addr3 = 9); skip_zero = 0 → 4 words in order.
- Wrap check: base = 16'hFFFE, len = 3 → addresses FFFE, FFFF, 0000. Backpressure check: out_ready low 5 cycles mid-dump → no loss, data held stable.
- watch_pc = 16'h0078 hit 3 times while out_ready = 1 → 3 trace words with out_is_trace = 1; same with out_ready = 0 → 1 word held, trace_overflow = 1.
- Reset asserted in DUMP → next cycle IDLE, out_valid = 0, cpu_reset = 1; start during RUN → ignored; len = 0 → DONE straight after drain.
